issue_ctrl: RTL
===============

# issue_ctrl

In-order issue controller between the decoder and the execute units. It gates each decoded instruction with a register scoreboard and structural-hazard checks, then issues it or stalls it. It tracks outstanding long-latency results from loads and mul/div, and sequences fence (drain) and wfi (sleep) as multi-cycle states.

## Interface
Parameters:
- LSU_DEPTH, 2, maximum outstanding memory operations (loads + stores); range 1..7
- CNT_W, $clog2(LSU_DEPTH+1), width of the outstanding-memory counter

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- inst_valid  in  1  decoded instruction present
- inst_ready  out  1  instruction consumed this cycle (issued or trapped)
- dec_valid, dec_wren, dec_rden1, dec_rden2  in  1 each  decoder legality and register-use flags
- dec_load, dec_store, dec_muldiv, dec_fence, dec_wfi  in  1 each  decoder class flags
- dec_waddr, dec_raddr1, dec_raddr2  in  5 each  register addresses
- issue  out  1  instruction dispatched to execute this cycle
- illegal  out  1  illegal-instruction trap request, one-cycle pulse
- mem_done  in  1  one memory operation completed (load data or store ack)
- muldiv_done  in  1  mul/div unit finished
- wb_valid  in  1  long-latency writeback this cycle
- wb_waddr  in  5  writeback destination
- irq_pending  in  1  enabled interrupt pending (wakes wfi)
- flush  in  1  pipeline redirect; abandons the current decode slot
- busy  out  1  FSM not in RUN

## Operation
- FSM states: RUN, DRAIN (fence), SLEEP (wfi).
- Scoreboard: 32-bit pend mask.
  - Set bit waddr on issue of load or muldiv with dec_wren=1.
  - Clear bit wb_waddr on wb_valid.
  - Bit 0 is never set.
  - Set and clear of the same bit in one cycle: set wins.
- Outstanding-memory counter mem_cnt:
  - +1 on issue of load/store; −1 on mem_done.
  - Both in the same cycle: unchanged.
  - mem_done with mem_cnt=0 is ignored; the counter saturates at 0.
- muldiv_busy: set on issue of muldiv, cleared on muldiv_done. Simultaneous set and clear: set wins.
- Hazard (RUN, inst_valid=1, dec_valid=1) stalls when any of these holds:
  - RAW: (dec_rden1 & pend[raddr1]) or (dec_rden2 & pend[raddr2]).
  - WAW: dec_wren & pend[waddr].
  - Memory full: (load|store) & mem_cnt==LSU_DEPTH.
  - Mul/div busy: dec_muldiv & muldiv_busy.
- Issue in RUN: issue = inst_ready = inst_valid & dec_valid & ~hazard & ~flush.
- Illegal in RUN: inst_valid & ~dec_valid & ~flush gives illegal=1 and inst_ready=1, issue=0, with no state change.
- Fence, when issued, moves the FSM to DRAIN:
  - DRAIN → RUN when pend==0, mem_cnt==0 and ~muldiv_busy.
  - No issue while in DRAIN.
- Wfi, when issued, moves the FSM to SLEEP:
  - SLEEP → RUN on irq_pending.
  - If irq_pending is already 1 at issue, the FSM stays in RUN.
- Flush:
  - Forces issue=0 and inst_ready=0 in the same cycle.
  - Next state is RUN, from any state.
  - pend, mem_cnt and muldiv_busy are kept, because in-flight results still write back.

## Timing
- Reset (async): FSM=RUN, pend=0, mem_cnt=0, muldiv_busy=0.
- Reset values of outputs: issue=0, illegal=0, inst_ready=0 while inst_valid=0, busy=0.
- issue, inst_ready and illegal are combinational from inputs and state, with zero-cycle latency.
- All state updates occur on the rising clock edge following issue/done.
- Without bypass, a dependent instruction issues no earlier than the cycle after wb_valid.
- DRAIN exit is evaluated on registered state; the first post-fence issue is the cycle after the drain condition holds.
- Reset mid-DRAIN or mid-SLEEP returns to RUN with all tracking cleared; later mem_done/wb_valid from stale operations are tolerated (saturation, clear of already-zero bit).

## Configuration
- ISSUE_CTRL_BYPASS_EN defined:
  - The RAW/WAW check masks pend with the current-cycle writeback, i.e. a register with wb_valid & wb_waddr==addr is treated as ready.
  - A dependent instruction issues in the same cycle as the writeback.
  - The set-wins rule is unchanged.
- Undefined: the check uses registered pend only, adding one extra stall cycle.

## Structure
- Shared package holds:
  - the issue_state_type enum (RUN, DRAIN, SLEEP);
  - an issue_ctrl_in_type struct bundling the dec_* fields;
  - an issue_ctrl_out_type struct for issue/illegal/busy.
- One sub-module, issue_scoreboard: the pend mask with set/clear/bypass lookup for three addresses.
- FSM, counter and muldiv_busy stay in issue_ctrl.

## Test plan
- Load r5 issued, then add r6,r5,r1 → add stalls until wb_valid(r5); with bypass it issues in the wb cycle, without bypass one cycle later.
- Three back-to-back loads, LSU_DEPTH=2 → third stalls until mem_done; mem_done coincident with issue keeps mem_cnt=2.
- mul then div → div stalls until muldiv_done; busy stays 0 throughout.
- Fence with two loads pending → busy=1 until both wb_valid and mem_done arrive, then returns to RUN and the next add issues.
- Wfi with irq_pending=0 → SLEEP; irq_pending=1 → RUN on the next edge. Wfi issued with irq_pending=1 → no SLEEP.
- Illegal (dec_valid=0) → illegal=1 for one cycle, issue=0. Assert reset mid-DRAIN → RUN, pend=0, mem_cnt=0.

Source files
------------

// File: rtl/issue_ctrl_pkg.sv
// issue_ctrl_pkg: shared types for the in-order issue controller.
// Build macro ISSUE_CTRL_BYPASS_EN enables same-cycle writeback bypass.
package issue_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2
  } issue_state_type;

  typedef struct packed {
    logic       valid;
    logic       wren;
    logic       rden1;
    logic       rden2;
    logic       load;
    logic       store;
    logic       muldiv;
    logic       fence;
    logic       wfi;
    logic [4:0] waddr;
    logic [4:0] raddr1;
    logic [4:0] raddr2;
  } issue_ctrl_in_type;

  typedef struct packed {
    logic issue;
    logic illegal;
    logic busy;
  } issue_ctrl_out_type;

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// issue_scoreboard: pending-writeback mask with three-port lookup.
// Ports: set_i/set_addr_i (issue of long op), clr_i/clr_addr_i (writeback),
// raddr1_i/raddr2_i/waddr_i lookups -> pend1_o/pend2_o/pendw_o, empty_o.
// ISSUE_CTRL_BYPASS_EN: lookups see the current-cycle writeback as ready.
module issue_scoreboard (
  input  logic       clock,
  input  logic       reset,
  input  logic       set_i,
  input  logic [4:0] set_addr_i,
  input  logic       clr_i,
  input  logic [4:0] clr_addr_i,
  input  logic [4:0] raddr1_i,
  input  logic [4:0] raddr2_i,
  input  logic [4:0] waddr_i,
  output logic       pend1_o,
  output logic       pend2_o,
  output logic       pendw_o,
  output logic       empty_o
);

  logic [31:0] pend_q;
  logic [31:0] pend_d;
  logic [31:0] look;

  // Clear first so a same-cycle set of the same bit wins.
  always_comb begin
    pend_d = pend_q;
    if (clr_i)
      pend_d[clr_addr_i] = 1'b0;
    if (set_i && set_addr_i != 5'd0)
      pend_d[set_addr_i] = 1'b1;
  end

`ifdef ISSUE_CTRL_BYPASS_EN
  always_comb begin
    look = pend_q;
    if (clr_i)
      look[clr_addr_i] = 1'b0;
  end
`else
  assign look = pend_q;
`endif

  assign pend1_o = look[raddr1_i];
  assign pend2_o = look[raddr2_i];
  assign pendw_o = look[waddr_i];
  assign empty_o = (pend_q == 32'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      pend_q <= 32'd0;
    else
      pend_q <= pend_d;
  end

endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: in-order issue gate with scoreboard, LSU/muldiv tracking,
// fence drain and wfi sleep. Ports: dec_* decode, inst_valid/inst_ready,
// issue/illegal/busy, mem_done/muldiv_done/wb_* completions, irq, flush.
// Macro ISSUE_CTRL_BYPASS_EN: writeback bypass into the hazard check.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int LSU_DEPTH = 2,
  parameter int CNT_W     = $clog2(LSU_DEPTH + 1)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inst_valid,
  output logic       inst_ready,
  input  logic       dec_valid,
  input  logic       dec_wren,
  input  logic       dec_rden1,
  input  logic       dec_rden2,
  input  logic       dec_load,
  input  logic       dec_store,
  input  logic       dec_muldiv,
  input  logic       dec_fence,
  input  logic       dec_wfi,
  input  logic [4:0] dec_waddr,
  input  logic [4:0] dec_raddr1,
  input  logic [4:0] dec_raddr2,
  output logic       issue,
  output logic       illegal,
  input  logic       mem_done,
  input  logic       muldiv_done,
  input  logic       wb_valid,
  input  logic [4:0] wb_waddr,
  input  logic       irq_pending,
  input  logic       flush,
  output logic       busy
);

  issue_ctrl_in_type  d;
  issue_ctrl_out_type o;
  issue_state_type    state_q, state_d;

  logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
  logic             md_q, md_d;
  logic             p1, p2, pw, sb_empty;
  logic             is_mem, full, hazard, run;
  logic             inc, dec, drained;

  assign d = '{valid:  dec_valid,
               wren:   dec_wren,
               rden1:  dec_rden1,
               rden2:  dec_rden2,
               load:   dec_load,
               store:  dec_store,
               muldiv: dec_muldiv,
               fence:  dec_fence,
               wfi:    dec_wfi,
               waddr:  dec_waddr,
               raddr1: dec_raddr1,
               raddr2: dec_raddr2};

  issue_scoreboard u_sb (
    .clock      (clock),
    .reset      (reset),
    .set_i      (o.issue & (d.load | d.muldiv) & d.wren),
    .set_addr_i (d.waddr),
    .clr_i      (wb_valid),
    .clr_addr_i (wb_waddr),
    .raddr1_i   (d.raddr1),
    .raddr2_i   (d.raddr2),
    .waddr_i    (d.waddr),
    .pend1_o    (p1),
    .pend2_o    (p2),
    .pendw_o    (pw),
    .empty_o    (sb_empty)
  );

  assign is_mem = d.load | d.store;
  assign full   = (mem_cnt_q == CNT_W'(LSU_DEPTH));
  assign run    = (state_q == RUN);

  assign hazard = (d.rden1 & p1)
                | (d.rden2 & p2)
                | (d.wren & pw)
                | (is_mem & full)
                | (d.muldiv & md_q);

  always_comb begin
    o.issue   = run & inst_valid & d.valid
              & ~hazard & ~flush;
    o.illegal = run & inst_valid & ~d.valid
              & ~flush;
    o.busy    = ~run;
  end

  assign issue      = o.issue;
  assign illegal    = o.illegal;
  assign busy       = o.busy;
  assign inst_ready = o.issue | o.illegal;

  // mem_done on an empty counter is a stale ack and is dropped.
  assign inc = o.issue & is_mem;
  assign dec = mem_done & (mem_cnt_q != '0);

  always_comb begin
    mem_cnt_d = mem_cnt_q;
    if (inc && !dec)
      mem_cnt_d = mem_cnt_q + CNT_W'(1);
    else if (dec && !inc)
      mem_cnt_d = mem_cnt_q - CNT_W'(1);
  end

  always_comb begin
    md_d = md_q;
    if (o.issue && d.muldiv)
      md_d = 1'b1;
    else if (muldiv_done)
      md_d = 1'b0;
  end

  assign drained = sb_empty & (mem_cnt_q == '0) & ~md_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (o.issue && d.fence)
          state_d = DRAIN;
        else if (o.issue && d.wfi && !irq_pending)
          state_d = SLEEP;
      end
      DRAIN:   if (drained) state_d = RUN;
      SLEEP:   if (irq_pending) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (flush)
      state_d = RUN;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      mem_cnt_q <= '0;
      md_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_cnt_q <= mem_cnt_d;
      md_q      <= md_d;
    end
  end

endmodule
